// File: rtl/encode_match_ctl.sv
// rtl/encode_match_ctl.sv - LZS encode sequencer: turns the byte stream plus hash candidates into literal/match/end tokens.
module encode_match_ctl #(
  parameter int LZF_WIDTH = 20,
  parameter int MAX_LEN   = 255,
  parameter int MIN_OFF   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_byte,
  input  logic [LZF_WIDTH-1:0] in_idx,
  input  logic                 in_last,
  input  logic                 cand_valid,
  input  logic [LZF_WIDTH-1:0] cand_ref,
  input  logic [7:0]           cand_b1,
  input  logic [7:0]           cand_b0,
  output logic [10:0]          hraddr,
  input  logic [7:0]           hdata,
  input  logic                 tok_full,
  output logic                 in_stall,
  output logic                 tok_valid,
  output logic                 tok_match,
  output logic [7:0]           tok_lit,
  output logic [10:0]          tok_off,
  output logic [7:0]           tok_len,
  output logic                 tok_end,
  output logic                 done
);

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_MATCH, S_FLUSH, S_END, S_DONE} state_t;

  state_t               state;
  logic [7:0]           pend_byte;
  logic [7:0]           len;
  logic [10:0]          ptr;
  logic [10:0]          off;
  logic [LZF_WIDTH-1:0] cand_off;
  logic                 cand_ok;
  logic                 take;
  logic                 at_max;
  logic                 byte_hit;

  assign in_stall = tok_full || (state == S_FLUSH) || (state == S_END) || (state == S_DONE);
  assign take     = in_valid && !in_stall;
  assign cand_off = in_idx - LZF_WIDTH'(1) - cand_ref;
  assign cand_ok  = cand_valid && (cand_b1 == pend_byte) && (cand_b0 == in_byte) &&
                    (cand_off >= LZF_WIDTH'(MIN_OFF)) && (cand_off <= LZF_WIDTH'(2047));
  assign at_max   = (len == 8'(MAX_LEN));
  assign byte_hit = (in_byte == hdata);

  // On acceptance the read is pointed at cand_ref+2 right away so the very next byte can be compared.
  always_comb begin
    hraddr = ptr;
    if (state == S_PEND && take && cand_ok)
      hraddr = cand_ref[10:0] + 11'd2;
    else if (state == S_MATCH && take && !at_max && byte_hit)
      hraddr = ptr + 11'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pend_byte <= '0;
      len       <= '0;
      ptr       <= '0;
      off       <= '0;
      tok_valid <= 1'b0;
      tok_match <= 1'b0;
      tok_lit   <= '0;
      tok_off   <= '0;
      tok_len   <= '0;
      tok_end   <= 1'b0;
      done      <= 1'b0;
    end else begin
      tok_valid <= 1'b0;
      tok_match <= 1'b0;
      tok_lit   <= '0;
      tok_off   <= '0;
      tok_len   <= '0;
      tok_end   <= 1'b0;
      case (state)
        S_IDLE: if (take) begin
          pend_byte <= in_byte;
          state     <= in_last ? S_FLUSH : S_PEND;
        end
        S_PEND: if (take) begin
          if (cand_ok) begin
            len <= 8'd2;
            off <= cand_off[10:0];
            ptr <= cand_ref[10:0] + 11'd2;
            if (in_last) begin
              tok_valid <= 1'b1;
              tok_match <= 1'b1;
              tok_off   <= cand_off[10:0];
              tok_len   <= 8'd2;
              state     <= S_END;
            end else begin
              state <= S_MATCH;
            end
          end else begin
            tok_valid <= 1'b1;
            tok_lit   <= pend_byte;
            pend_byte <= in_byte;
            state     <= in_last ? S_FLUSH : S_PEND;
          end
        end
        S_MATCH: if (take) begin
          if (!at_max && byte_hit) begin
            if (in_last) begin
              tok_valid <= 1'b1;
              tok_match <= 1'b1;
              tok_off   <= off;
              tok_len   <= len + 8'd1;
              state     <= S_END;
            end else begin
              len <= len + 8'd1;
              ptr <= ptr + 11'd1;
            end
          end else begin
            tok_valid <= 1'b1;
            tok_match <= 1'b1;
            tok_off   <= off;
            tok_len   <= len;
            pend_byte <= in_byte;
            state     <= in_last ? S_FLUSH : S_PEND;
          end
        end
        S_FLUSH: if (!tok_full) begin
          tok_valid <= 1'b1;
          tok_lit   <= pend_byte;
          state     <= S_END;
        end
        S_END: if (!tok_full) begin
          tok_valid <= 1'b1;
          tok_end   <= 1'b1;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: done <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_match_ctl.sv
// tb/tb_encode_match_ctl.sv - directed bench for encode_match_ctl with a history-RAM model.
module tb_encode_match_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, cand_valid = 1'b0, tok_full = 1'b0;
  logic [7:0]  in_byte = '0, cand_b1 = '0, cand_b0 = '0, hdata = '0;
  logic [19:0] in_idx = '0, cand_ref = '0;
  logic [10:0] hraddr, tok_off;
  logic        in_stall, tok_valid, tok_match, tok_end, done;
  logic [7:0]  tok_lit, tok_len;

  logic [7:0]  hist [2048];
  logic [28:0] got[$];
  logic [28:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  encode_match_ctl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_idx(in_idx),
    .in_last(in_last), .cand_valid(cand_valid), .cand_ref(cand_ref), .cand_b1(cand_b1),
    .cand_b0(cand_b0), .hraddr(hraddr), .hdata(hdata), .tok_full(tok_full),
    .in_stall(in_stall), .tok_valid(tok_valid), .tok_match(tok_match), .tok_lit(tok_lit),
    .tok_off(tok_off), .tok_len(tok_len), .tok_end(tok_end), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) hdata <= hist[hraddr];

  function automatic logic [28:0] tk(input bit e, input bit m, input logic [7:0] l,
                                     input logic [10:0] o, input logic [7:0] n);
    return {e, m, l, o, n};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tok_valid) got.push_back({tok_end, tok_match, tok_lit, tok_off, tok_len});
    if (in_valid) chk("no_input_while_stalled", {31'd0, in_stall}, 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; cand_valid = 1'b0; tok_full = 1'b0;
    repeat (2) @(negedge clk);
    got.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input logic [19:0] idx, input bit last,
                     input bit cv, input logic [19:0] cref);
    @(negedge clk);
    hist[idx[10:0]] = b;
    in_valid   = 1'b1;
    in_byte    = b;
    in_idx     = idx;
    in_last    = last;
    cand_valid = cv;
    cand_ref   = cref;
    cand_b1    = hist[cref[10:0]];
    cand_b0    = hist[cref[10:0] + 11'd1];
  endtask

  task automatic gap(input int n, input logic [10:0] exp_addr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0; cand_valid = 1'b0;
      #1 chk($sformatf("hraddr_gap%0d", k), {21'd0, hraddr}, {21'd0, exp_addr});
    end
  endtask

  task automatic finish_check(input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; cand_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_ntok"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_tok%0d", tag, i), (i < got.size()) ? {3'd0, got[i]} : 32'hFFFFFFFF,
          {3'd0, exp_q[i]});
  endtask

  initial begin
    logic [7:0]  s2 [10];
    logic [7:0]  pat [8];
    logic [19:0] base;
    int          sum;
    s2  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h41, 8'h42, 8'h43, 8'h44, 8'h58};
    pat = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    for (int i = 0; i < 2048; i++) hist[i] = 8'h00;

    // Reset state
    do_reset();
    #1;
    chk("rst_tok_valid", {31'd0, tok_valid}, 32'd0);
    chk("rst_tok_fields", {3'd0, tok_end, tok_match, tok_lit, tok_off, tok_len}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_stall", {31'd0, in_stall}, 32'd0);

    // ABCD, no candidates
    do_reset();
    for (int i = 0; i < 4; i++) put(8'h41 + 8'(i), 20'(i), i == 3, 1'b0, '0);
    for (int i = 0; i < 4; i++) exp_q.push_back(tk(0, 0, 8'h41 + 8'(i), 0, 0));
    exp_q.push_back(tk(1, 0, 0, 0, 0));
    finish_check("abcd");

    // ABCDEABCDX with a candidate at idx 6
    do_reset();
    for (int i = 0; i < 10; i++) put(s2[i], 20'(i), i == 9, i == 6, '0);
    for (int i = 0; i < 5; i++) exp_q.push_back(tk(0, 0, 8'h41 + 8'(i), 0, 0));
    exp_q.push_back(tk(0, 1, 0, 11'd5, 8'd4));
    exp_q.push_back(tk(0, 0, 8'h58, 0, 0));
    exp_q.push_back(tk(1, 0, 0, 0, 0));
    finish_check("match");

    // Offset 2 is below the minimum and must be rejected
    do_reset();
    put(8'h41, 20'd0, 0, 0, '0);
    put(8'h42, 20'd1, 0, 0, '0);
    put(8'h41, 20'd2, 0, 0, '0);
    put(8'h42, 20'd3, 0, 1, 20'd0);
    put(8'h58, 20'd4, 1, 0, '0);
    exp_q.push_back(tk(0, 0, 8'h41, 0, 0));
    exp_q.push_back(tk(0, 0, 8'h42, 0, 0));
    exp_q.push_back(tk(0, 0, 8'h41, 0, 0));
    exp_q.push_back(tk(0, 0, 8'h42, 0, 0));
    exp_q.push_back(tk(0, 0, 8'h58, 0, 0));
    exp_q.push_back(tk(1, 0, 0, 0, 0));
    finish_check("minoff");

    // 300 bytes of an 8-byte pattern: match splits at MAX_LEN
    do_reset();
    for (int i = 0; i < 300; i++) put(pat[i % 8], 20'(i), i == 299, i >= 9, 20'(i - 9));
    for (int i = 0; i < 8; i++) exp_q.push_back(tk(0, 0, pat[i], 0, 0));
    exp_q.push_back(tk(0, 1, 0, 11'd8, 8'd255));
    exp_q.push_back(tk(0, 1, 0, 11'd8, 8'd37));
    exp_q.push_back(tk(1, 0, 0, 0, 0));
    finish_check("maxlen");
    sum = 0;
    foreach (got[i]) sum += got[i][27] ? int'(got[i][7:0]) : (got[i][28] ? 0 : 1);
    chk("maxlen_byte_sum", sum, 32'd300);

    // tok_full held during S_FLUSH
    do_reset();
    put(8'h41, 20'd0, 0, 0, '0);
    put(8'h42, 20'd1, 1, 0, '0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; tok_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("full_stall%0d", k), {31'd0, in_stall}, 32'd1);
      chk($sformatf("full_novalid%0d", k), {31'd0, tok_valid}, 32'd0);
    end
    tok_full = 1'b0;
    @(negedge clk);
    #1;
    chk("full_release_valid", {31'd0, tok_valid}, 32'd1);
    chk("full_release_lit", {24'd0, tok_lit}, 32'h42);
    exp_q.push_back(tk(0, 0, 8'h41, 0, 0));
    exp_q.push_back(tk(0, 0, 8'h42, 0, 0));
    exp_q.push_back(tk(1, 0, 0, 0, 0));
    finish_check("full");

    // Gaps inside a match, with indices wrapping past 2^20 and the history address past 2047
    do_reset();
    base = 20'hFFFFD;
    for (int i = 0; i < 10; i++) begin
      put(s2[i], base + 20'(i), i == 9, i == 6, base);
      if (i >= 6 && i <= 8) gap(3, base[10:0] + 11'(i - 4));
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(tk(0, 0, 8'h41 + 8'(i), 0, 0));
    exp_q.push_back(tk(0, 1, 0, 11'd5, 8'd4));
    exp_q.push_back(tk(0, 0, 8'h58, 0, 0));
    exp_q.push_back(tk(1, 0, 0, 0, 0));
    finish_check("gaps");

    // Reset in the middle of a match discards it
    do_reset();
    for (int i = 0; i < 8; i++) put(s2[i], 20'(i), 0, i == 6, '0);
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_no_tokens", got.size(), 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
